word_serializer: RTL and testbench



---
 rtl/serial_pkg.sv | 13 +
 rtl/bit_tick_gen.sv | 35 +++
 rtl/word_serializer.sv | 93 +++++++++
 tb/tb_word_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and widths for the serial shift-register path:
// serializer states and the word width used by the downstream register.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  localparam int WORD_W = 32;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: while running, asserts tick once every DIV clocks,
// starting DIV-1 cycles after a clear.
module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_r;

  // Divider counter; wraps to zero on the tick cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      div_cnt_r <= {CW{1'b0}};
    end else if (run && (div_cnt_r == LAST_CNT)) begin
      div_cnt_r <= {CW{1'b0}};
    end else if (run) begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  assign tick = (div_cnt_r == LAST_CNT);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end for the shift register: accepts a word over
// valid/ready and emits it MSB first with one enable strobe per bit period.
module word_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DIV   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_bit,
  output logic             ser_enable,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state_r;
  ser_state_t       state_nxt_s;
  logic [WIDTH-1:0] hold_r;
  logic [BW-1:0]    bit_cnt_r;
  logic             tick_s;
  logic             accept_s;
  logic             strobe_s;

  assign accept_s = load_valid & load_ready;
  assign strobe_s = (state_r == SHIFT) & tick_s;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .run   (state_r == SHIFT),
    .clr   (accept_s),
    .tick  (tick_s)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE is a single-cycle pass-through back to IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = SHIFT;
        else          state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (strobe_s && (bit_cnt_r == LAST_BIT)) state_nxt_s = DONE;
        else                                      state_nxt_s = SHIFT;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Holding register and bit counter; shift happens after the MSB is strobed out
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_r    <= {WIDTH{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
    end else if (accept_s) begin
      hold_r    <= data_in;
      bit_cnt_r <= {BW{1'b0}};
    end else if (strobe_s) begin
      hold_r    <= {hold_r[WIDTH-2:0], 1'b0};
      bit_cnt_r <= bit_cnt_r + BW'(1);
    end else begin
      hold_r    <= hold_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign load_ready = (state_r == IDLE) & ~reset;
  assign busy       = (state_r != IDLE) & ~reset;
  assign ser_enable = strobe_s & ~reset;
  assign ser_bit    = hold_r[WIDTH-1] & ~reset;
  assign done       = (state_r == DONE) & ~reset;

endmodule

// File: tb/tb_word_serializer.sv
// Randomized self-checking bench: two serializers (DIV=1 and DIV=4) each
// feed a modelled 32-bit downstream shift register.
module tb_word_serializer;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    load_valid;
  logic [W-1:0]  data_in [2];
  logic [1:0]    load_ready, ser_bit, ser_enable, busy, done;

  logic [W-1:0]  shreg   [2];
  int            strobes [2];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clock = ~clock;

  word_serializer #(.WIDTH(W), .DIV(1)) dut_div1 (
    .clock(clock), .reset(reset), .data_in(data_in[0]),
    .load_valid(load_valid[0]), .load_ready(load_ready[0]),
    .ser_bit(ser_bit[0]), .ser_enable(ser_enable[0]),
    .busy(busy[0]), .done(done[0])
  );

  word_serializer #(.WIDTH(W), .DIV(4)) dut_div4 (
    .clock(clock), .reset(reset), .data_in(data_in[1]),
    .load_valid(load_valid[1]), .load_ready(load_ready[1]),
    .ser_bit(ser_bit[1]), .ser_enable(ser_enable[1]),
    .busy(busy[1]), .done(done[1])
  );

  // Downstream shift registers driven by each serializer
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (ser_enable[d]) begin
        shreg[d]   <= {shreg[d][W-2:0], ser_bit[d]};
        strobes[d] <= strobes[d] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq(tag, 32'({load_ready[d], ser_bit[d], ser_enable[d], busy[d], done[d]}), 32'd0);
    end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clock);
      check_eq("idle_en", 32'(ser_enable[d]), 32'd0);
      check_eq("idle_ready", 32'(load_ready[d]), 32'd1);
    end
  endtask

  // Offer word w at the current negedge and check the whole serialization
  // against the timing rules: strobe k (1-based) in cycle k*div after accept,
  // carrying w[W-k]; done in cycle W*div+1; ready again in cycle W*div+2.
  // With bp_en, a second word is offered from cycle 5 and held.
  task automatic serialize(input int d, input logic [W-1:0] w, input int div,
                           input bit bp_en, input logic [W-1:0] bp_w);
    int last;
    bit exp_en;
    last = W * div;
    check_eq("accept_ready", 32'(load_ready[d]), 32'd1);
    data_in[d]    = w;
    load_valid[d] = 1'b1;
    @(negedge clock);
    load_valid[d] = 1'b0;
    data_in[d]    = $urandom;
    for (int c = 1; c <= last + 2; c++) begin
      exp_en = ((c % div) == 0) && (c <= last);
      check_eq("ser_enable", 32'(ser_enable[d]), 32'(exp_en));
      if (exp_en) check_eq("ser_bit", 32'(ser_bit[d]), 32'(w[W - c / div]));
      check_eq("busy", 32'(busy[d]), 32'(c <= last + 1));
      check_eq("done", 32'(done[d]), 32'(c == last + 1));
      check_eq("load_ready", 32'(load_ready[d]), 32'(c == last + 2));
      if (bp_en && c >= 5) begin
        load_valid[d] = 1'b1;
        data_in[d]    = bp_w;
      end
      if (c < last + 2) @(negedge clock);
    end
    check_eq("downstream_word", shreg[d], w);
    check_eq("downstream_out", 32'(shreg[d][W-1]), 32'(w[W-1]));
  endtask

  initial begin
    int s0;
    reset      = 1'b1;
    load_valid = 2'b00;
    data_in[0] = '0;
    data_in[1] = '0;
    shreg[0]   = '0;
    shreg[1]   = '0;
    strobes[0] = 0;
    strobes[1] = 0;

    // 1. reset then idle
    repeat (2) begin
      @(negedge clock);
      check_all_zero("reset_outputs");
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("post_reset_ready", 32'(load_ready[d]), 32'd1);
      check_eq("post_reset_busy", 32'(busy[d]), 32'd0);
      check_eq("post_reset_en", 32'(ser_enable[d]), 32'd0);
    end
    idle(0, 2);

    // 2. single word, DIV=1
    serialize(0, 32'hDEADBEEF, 1, 1'b0, '0);

    // 3. divider, DIV=4
    serialize(1, 32'h80000001, 4, 1'b0, '0);

    // 4. back-pressure: second word held during busy, taken on first IDLE cycle
    serialize(0, 32'hFFFFFFFF, 1, 1'b1, 32'h12345678);
    serialize(0, 32'h12345678, 1, 1'b0, '0);
    idle(0, 1);

    // 5. reset after the 10th strobe
    data_in[0]    = 32'hAAAAAAAA;
    load_valid[0] = 1'b1;
    @(negedge clock);
    load_valid[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check_eq("pre_abort_en", 32'(ser_enable[0]), 32'd1);
      check_eq("pre_abort_bit", 32'(ser_bit[0]), 32'(c % 2 == 1));
      @(negedge clock);
    end
    s0    = strobes[0];
    reset = 1'b1;
    #1;
    check_all_zero("abort_outputs");
    repeat (2) begin
      @(negedge clock);
      check_all_zero("abort_hold");
    end
    reset = 1'b0;
    #1;
    check_eq("abort_ready", 32'(load_ready[0]), 32'd1);
    check_eq("abort_busy", 32'(busy[0]), 32'd0);
    idle(0, 3);
    check_eq("abort_strobes", 32'(strobes[0] - s0), 32'd0);
    serialize(0, 32'h0000FFFF, 1, 1'b0, '0);

    // 6. load_valid together with reset: no accept until reset drops
    reset         = 1'b1;
    data_in[0]    = 32'hC3A5_5A3C;
    load_valid[0] = 1'b1;
    s0            = strobes[0];
    @(negedge clock);
    check_all_zero("valid_in_reset");
    reset = 1'b0;
    #1;
    check_eq("no_accept_in_reset", 32'(load_ready[0]), 32'd1);
    check_eq("no_strobe_in_reset", 32'(strobes[0] - s0), 32'd0);
    serialize(0, 32'hC3A5_5A3C, 1, 1'b0, '0);

    // random words on both serializers
    for (int i = 0; i < 6; i++) begin
      serialize(0, $urandom, 1, 1'b0, '0);
      idle(0, $urandom_range(0, 3));
    end
    for (int i = 0; i < 2; i++) begin
      serialize(1, $urandom, 4, 1'b0, '0);
      idle(1, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
